mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 33 +++
 rtl/ram_sp.sv | 27 ++
 rtl/mem_responder.sv | 141 ++++++++++++++
 tb/tb_mem_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared command codes, address map constants and state type for mem_responder.
package mem_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10,
    MRSVD  = 2'b11
  } mem_cmd_e;

  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR  = 9'h140;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_LED,
    REGION_SW,
    REGION_NONE
  } region_e;

  function automatic region_e decode_addr(input logic [8:0] addr);
    if (!addr[8])          return REGION_RAM;
    if (addr == LED_ADDR)  return REGION_LED;
    if (addr == SW_ADDR)   return REGION_SW;
    return REGION_NONE;
  endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port RAM: synchronous write, synchronous read, write-first on a same-cycle read/write.
module ram_sp #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the array and its read register have no reset so they map onto block RAM;
  // the read register only moves on re, which lets the consumer rely on it holding.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= we ? wdata : mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// CPU-facing memory responder: RAM, LED register, switch port and sticky error flag.
// Define MEM_INIT_CLEAR_EN to compile in the post-reset RAM clear (INIT state).
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mem_cmd,
  input  logic [8:0]       mem_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic [7:0]       sw,
  output logic [WIDTH-1:0] read_data,
  output logic [7:0]       led,
  output logic             ready,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);

  region_e          region;
  logic             ram_we, ram_re;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata, ram_rdata;

  logic [7:0]       led_q, led_d;
  logic             err_q, err_d;
  logic             rd_from_ram_q, rd_from_ram_d;
  logic [WIDTH-1:0] rd_other_q, rd_other_d;

  assign region = decode_addr(mem_addr);

`ifdef MEM_INIT_CLEAR_EN
  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_INIT) begin
      clr_cnt_d = clr_cnt_q + AW'(1);
      if (clr_cnt_q == AW'(DEPTH - 1)) begin
        state_d   = ST_RUN;
        clr_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign ready = (state_q == ST_RUN);
`else
  assign ready = 1'b1;
`endif

  // NOTE: every signal gets a default before the branches so no path can infer a latch.
  always_comb begin
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    ram_addr      = mem_addr[AW-1:0];
    ram_wdata     = write_data;
    led_d         = led_q;
    err_d         = err_q;
    rd_from_ram_d = rd_from_ram_q;
    rd_other_d    = rd_other_q;
`ifdef MEM_INIT_CLEAR_EN
    if (state_q == ST_INIT) begin
      ram_we    = 1'b1;
      ram_addr  = clr_cnt_q;
      ram_wdata = '0;
    end else
`endif
    begin
      unique case (mem_cmd_e'(mem_cmd))
        MREAD: begin
          rd_from_ram_d = (region == REGION_RAM);
          rd_other_d    = '0;
          case (region)
            REGION_RAM:  ram_re = 1'b1;
            REGION_SW:   rd_other_d = WIDTH'(sw);
            REGION_NONE: err_d = 1'b1;
            default:     ;
          endcase
        end
        MWRITE: begin
          case (region)
            REGION_RAM: ram_we = 1'b1;
            REGION_LED: led_d = write_data[7:0];
            default:    err_d = 1'b1;
          endcase
        end
        MRSVD:   err_d = 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q         <= '0;
      err_q         <= 1'b0;
      rd_from_ram_q <= 1'b0;
      rd_other_q    <= '0;
    end else begin
      led_q         <= led_d;
      err_q         <= err_d;
      rd_from_ram_q <= rd_from_ram_d;
      rd_other_q    <= rd_other_d;
    end
  end

  ram_sp #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Non-RAM reads come from rd_other_q, so reset zeroes read_data without touching the RAM.
  assign read_data = rd_from_ram_q ? ram_rdata : rd_other_q;
  assign led       = led_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: reference model plus read-response scoreboard queue.
// Covers both builds; INIT-specific checks are active when MEM_INIT_CLEAR_EN is defined.
module tb_mem_responder;

`ifdef MEM_INIT_CLEAR_EN
  localparam int INIT_CYCLES = 256;
`else
  localparam int INIT_CYCLES = 0;
`endif

  localparam logic [1:0] C_NONE = 2'b00, C_READ = 2'b01, C_WRITE = 2'b10, C_RSVD = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  mem_cmd = C_NONE;
  logic [8:0]  mem_addr = '0;
  logic [15:0] write_data = '0;
  logic [7:0]  sw = '0;
  logic [15:0] read_data;
  logic [7:0]  led;
  logic        ready;
  logic        err;

  mem_responder #(.DEPTH(256), .WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .sw         (sw),
    .read_data  (read_data),
    .led        (led),
    .ready      (ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem_m [256];
  logic [7:0]  led_m;
  logic        err_m;
  logic [15:0] rd_m;
  int          init_left;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [8:0] addr);
    if (!addr[8])       return mem_m[addr[7:0]];
    if (addr == 9'h140) return {8'h00, sw};
    return 16'h0000;
  endfunction

  task automatic cycle(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
    @(negedge clk);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = wd;
    if (init_left == 0) begin
      case (cmd)
        C_READ: begin
          exp_q.push_back(model_read(addr));
          if (addr[8] && addr != 9'h100 && addr != 9'h140) err_m = 1'b1;
        end
        C_WRITE: begin
          if (!addr[8])            mem_m[addr[7:0]] = wd;
          else if (addr == 9'h100) led_m = wd[7:0];
          else                     err_m = 1'b1;
        end
        C_RSVD:  err_m = 1'b1;
        default: ;
      endcase
    end else begin
      init_left--;
      if (init_left == 0)
        for (int i = 0; i < 256; i++) mem_m[i] = 16'h0000;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) rd_m = exp_q.pop_front();
    check("read_data", read_data, rd_m);
    check("led", {8'h00, led}, {8'h00, led_m});
    check("err", {15'h0, err}, {15'h0, err_m});
    check("ready", {15'h0, ready}, {15'h0, init_left == 0});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b0;
    mem_cmd = C_NONE;
    #1;
    led_m     = 8'h00;
    err_m     = 1'b0;
    rd_m      = 16'h0000;
    init_left = INIT_CYCLES;
    exp_q.delete();
    check("rst_read_data", read_data, 16'h0000);
    check("rst_led", {8'h00, led}, 16'h0000);
    check("rst_err", {15'h0, err}, 16'h0000);
    check("rst_ready", {15'h0, ready}, {15'h0, INIT_CYCLES == 0});
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(C_NONE, 9'h000, 16'h0000);
  endtask

  initial begin
    do_reset();
`ifdef MEM_INIT_CLEAR_EN
    idle(INIT_CYCLES);
    cycle(C_READ, 9'h0FF, 16'h0);
    cycle(C_READ, 9'h000, 16'h0);
`endif
    // write then immediate read, then held through a second cycle
    cycle(C_WRITE, 9'h012, 16'hBEEF);
    cycle(C_READ,  9'h012, 16'h0);
    cycle(C_NONE,  9'h012, 16'h0);
    // a later write must not disturb the held response
    cycle(C_WRITE, 9'h012, 16'h5555);
    cycle(C_NONE,  9'h000, 16'h0);
    cycle(C_READ,  9'h012, 16'h0);
    // RAM boundaries
    cycle(C_WRITE, 9'h000, 16'h0A0A);
    cycle(C_WRITE, 9'h0FF, 16'hF00F);
    cycle(C_READ,  9'h0FF, 16'h0);
    cycle(C_READ,  9'h000, 16'h0);
    // random RAM traffic
    for (int i = 0; i < 8; i++) begin
      logic [8:0]  a;
      logic [15:0] d;
      a = 9'($urandom_range(1, 254));
      d = 16'($urandom);
      cycle(C_WRITE, a, d);
      cycle(C_READ,  a, 16'h0);
    end
    // switches and LED
    sw = 8'hA5;
    cycle(C_READ,  9'h140, 16'h0);
    cycle(C_WRITE, 9'h100, 16'h1234);
    cycle(C_READ,  9'h100, 16'h0);
    sw = 8'h3C;
    cycle(C_READ,  9'h140, 16'h0);
    cycle(C_NONE,  9'h000, 16'h0);
    // illegal accesses: err sticks, led untouched
    cycle(C_WRITE, 9'h140, 16'hFFFF);
    cycle(C_RSVD,  9'h100, 16'h00EE);
    cycle(C_READ,  9'h1FF, 16'h0);
    cycle(C_WRITE, 9'h1C0, 16'h0077);
    idle(2);
    cycle(C_READ,  9'h012, 16'h0);

    do_reset();
`ifdef MEM_INIT_CLEAR_EN
    // reset in the middle of the clear, then commands during INIT are ignored
    idle(100);
    do_reset();
    cycle(C_WRITE, 9'h050, 16'hDEAD);
    cycle(C_RSVD,  9'h050, 16'h0);
    cycle(C_READ,  9'h1FF, 16'h0);
    cycle(C_WRITE, 9'h100, 16'h00CC);
    idle(INIT_CYCLES - 4);
    cycle(C_READ,  9'h050, 16'h0);
    cycle(C_READ,  9'h012, 16'h0);
    cycle(C_READ,  9'h0FF, 16'h0);
`else
    // RAM contents survive reset
    cycle(C_READ,  9'h0FF, 16'h0);
    cycle(C_READ,  9'h000, 16'h0);
`endif
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
